// File: rtl/fibonacci_pkg.sv
// Shared types and constants for the fibonacci engine scheduler.
package fibonacci_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } t_sched_state;

    typedef struct packed {
        logic       valid;
        logic       error;
        logic [7:0] result;
    } t_sched_rsp;

    localparam logic [2:0] F_MAX_TERM   = 3'd7;
    localparam logic [7:0] F_ERR_RESULT = 8'd0;

endpackage

// File: rtl/fibonacci_sched_if.sv
// Requester-side request/response bundle of the fibonacci scheduler.
interface fibonacci_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][2:0] req_term;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [7:0]              rsp_result;
    logic                    rsp_error;

    modport master (
        output req_valid, req_term,
        input  req_ready, rsp_valid, rsp_result, rsp_error
    );

    modport slave (
        input  req_valid, req_term,
        output req_ready, rsp_valid, rsp_result, rsp_error
    );
endinterface

// File: rtl/fibonacci_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module fibonacci_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    // Walk offsets from the pointer; the first hit blocks all later ones.
    always_comb begin
        int  idx;
        logic hit;
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = 0;
        hit      = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx        = (int'(ptr) + off) % NUM_REQ;
            hit        = req[idx] & ~any_req;
            grant[idx] = hit;
            grant_id   = hit ? ID_W'(idx) : grant_id;
            any_req    = any_req | req[idx];
        end
    end

endmodule

// File: rtl/fibonacci_sched.sv
// Shares one fibonacci engine between NUM_REQ requesters with round-robin
// arbitration, a WAIT timeout and a one-cycle response pulse to the winner.
module fibonacci_sched
    import fibonacci_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    fibonacci_sched_if.slave  bus,
    output logic              eng_rst,
    output logic [2:0]        eng_term,
    input  logic              eng_valid,
    input  logic [7:0]        eng_result,
    output logic              busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    t_sched_state        state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     id_r;
    logic [CNT_W-1:0]    cnt_r;
    t_sched_rsp          rsp_r;
    logic                eng_rst_r;
    logic [2:0]          eng_term_r;
    logic                busy_r;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_id_s;
    logic                any_req_s;
    logic [NUM_REQ-1:0]  rsp_onehot_s;

    fibonacci_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr_r),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .any_req  (any_req_s)
    );

    // Accept strobe is only offered while the engine is free.
    always_comb begin
        if (state_r == S_IDLE) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Steer the registered response flag onto the granted requester's bit.
    always_comb begin
        rsp_onehot_s = '0;
        if (rsp_r.valid) begin
            rsp_onehot_s[id_r] = 1'b1;
        end else begin
            rsp_onehot_s = '0;
        end
    end

    assign bus.rsp_valid  = rsp_onehot_s;
    assign bus.rsp_result = rsp_r.result;
    assign bus.rsp_error  = rsp_r.error;
    // rst is ORed in so the engine is held in reset during the reset cycle itself.
    assign eng_rst        = eng_rst_r | rst;
    assign eng_term       = eng_term_r;
    assign busy           = busy_r;

    // Scheduler FSM with latched grant, timeout counter and engine drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ptr_r      <= '0;
            id_r       <= '0;
            cnt_r      <= '0;
            rsp_r      <= '0;
            eng_rst_r  <= 1'b1;
            eng_term_r <= 3'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (any_req_s) begin
                        id_r       <= grant_id_s;
                        eng_term_r <= bus.req_term[grant_id_s];
                        busy_r     <= 1'b1;
                        state_r    <= S_LAUNCH;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    cnt_r     <= '0;
                    eng_rst_r <= 1'b0;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    // A valid result takes priority over a coincident timeout.
                    if (eng_valid) begin
                        rsp_r     <= '{valid: 1'b1, error: 1'b0, result: eng_result};
                        eng_rst_r <= 1'b1;
                        state_r   <= S_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_r     <= '{valid: 1'b1, error: 1'b1, result: F_ERR_RESULT};
                        eng_rst_r <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    rsp_r.valid <= 1'b0;
                    ptr_r       <= (id_r == ID_LAST) ? '0 : id_r + ID_W'(1);
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    rsp_r.valid <= 1'b0;
                    eng_rst_r   <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
